// File: rtl/spi_bridge_pkg.sv
// Shared definitions for the AHB-to-SPI bridge: packet layout, widths and SPI-side FSM states.
package spi_bridge_pkg;

  localparam int PKT_W        = 41;
  localparam int DATA_W       = 32;
  localparam int ADDR_W       = 8;
  localparam int BIT_CNT_W    = 6;

  localparam int PKT_RW_BIT   = 40;
  localparam int PKT_ADDR_MSB = 39;
  localparam int PKT_ADDR_LSB = 32;
  localparam int PKT_DATA_MSB = 31;
  localparam int PKT_DATA_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_SHIFT = 3'd3,
    S_PUSH  = 3'd4,
    S_GAP   = 3'd5
  } spi_state_e;

  // Plain-vector copies so a corrupted state register can still be decoded back to IDLE.
  localparam logic [2:0] ST_IDLE  = S_IDLE;
  localparam logic [2:0] ST_FETCH = S_FETCH;
  localparam logic [2:0] ST_LOAD  = S_LOAD;
  localparam logic [2:0] ST_SHIFT = S_SHIFT;
  localparam logic [2:0] ST_PUSH  = S_PUSH;
  localparam logic [2:0] ST_GAP   = S_GAP;

  function automatic logic pkt_is_write(input logic [PKT_W-1:0] pkt);
    return pkt[PKT_RW_BIT];
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: CLK_DIV HCLK cycles per half-period, with one-cycle strobes
// marking the cycle in which SCLK is about to rise or fall.
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic HCLK,
  input  logic HRESET,
  input  logic clr,
  input  logic en,
  output logic rise_stb,
  output logic fall_stb,
  output logic sclk
);
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             half_done;

  assign half_done = en && (cnt_q == CNT_MAX);
  assign rise_stb  = half_done && !sclk_q;
  assign fall_stb  = half_done && sclk_q;
  assign sclk      = sclk_q;

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (clr) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (half_done) begin
      cnt_d  = '0;
      sclk_d = !sclk_q;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_fifo_master.sv
// SPI-side end of the AHB-to-SPI bridge: pops command packets from TxFIFO, runs one
// mode-0 frame per packet and pushes the read data of read frames into RxFIFO.
module spi_fifo_master
  import spi_bridge_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic [PKT_W-1:0]  DATA_from_TxFIFO,
  input  logic              TxFIFO_empty,
  output logic              TxFIFO_rd_en,
  output logic [DATA_W-1:0] DATA_to_RxFIFO,
  output logic              RxFIFO_wr_en,
  input  logic              RxFIFO_full,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO,
  output logic              SS_N,
  output logic              busy
);
  localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

  logic [2:0]           state_q, state_d;
  logic [PKT_W-1:0]     tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0]    rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0]    rx_data_q, rx_data_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic                 rw_q, rw_d;
  logic                 ss_n_q, ss_n_d;
  logic                 rd_en_q, rd_en_d;
  logic                 wr_en_q, wr_en_d;
  logic                 rise_stb, fall_stb;

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .clr      (state_q == ST_LOAD),
    .en       (state_q == ST_SHIFT),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb),
    .sclk     (SCLK)
  );

  // MOSI is the top of the shift register, so clearing the register idles the line low.
  assign MOSI           = tx_sr_q[PKT_W-1];
  assign SS_N           = ss_n_q;
  assign TxFIFO_rd_en   = rd_en_q;
  assign RxFIFO_wr_en   = wr_en_q;
  assign DATA_to_RxFIFO = rx_data_q;
  assign busy           = (state_q != ST_IDLE);

  always_comb begin
    state_d   = state_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    rw_d      = rw_q;
    ss_n_d    = ss_n_q;
    rd_en_d   = 1'b0;
    wr_en_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!TxFIFO_empty) begin
          rd_en_d = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        tx_sr_d   = DATA_from_TxFIFO;
        rw_d      = pkt_is_write(DATA_from_TxFIFO);
        rx_sr_d   = '0;
        bit_cnt_d = BIT_CNT_W'(PKT_W);
        ss_n_d    = 1'b0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        // Only the last DATA_W bits carry slave read data; address-phase MISO is dropped.
        if (rise_stb && (bit_cnt_q <= BIT_CNT_W'(DATA_W))) begin
          rx_sr_d = {rx_sr_q[DATA_W-2:0], MISO};
        end
        if (fall_stb) begin
          bit_cnt_d = bit_cnt_q - 1'b1;
          if (bit_cnt_d != '0) begin
            tx_sr_d = {tx_sr_q[PKT_W-2:0], 1'b0};
          end else begin
            tx_sr_d   = '0;
            ss_n_d    = 1'b1;
            gap_cnt_d = '0;
            state_d   = rw_q ? ST_GAP : ST_PUSH;
          end
        end
      end
      ST_PUSH: begin
        if (!RxFIFO_full) begin
          rx_data_d = rx_sr_q;
          wr_en_d   = 1'b1;
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q   <= ST_IDLE;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      rw_q      <= 1'b0;
      ss_n_q    <= 1'b1;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      rw_q      <= rw_d;
      ss_n_q    <= ss_n_d;
      rd_en_q   <= rd_en_d;
      wr_en_q   <= wr_en_d;
    end
  end

endmodule

// File: tb/tb_spi_fifo_master.sv
// Self-checking bench for spi_fifo_master: queue-based TxFIFO and SPI slave models,
// expectations derived from packet contents and frame timing rules.
`timescale 1ns/1ps
module tb_spi_fifo_master;
  localparam int CLK_DIV = 4;
  localparam int CS_GAP  = 2;
  localparam int FRAME_LOW = 82 * CLK_DIV;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;

  logic [40:0] DATA_from_TxFIFO;
  logic        TxFIFO_empty, TxFIFO_rd_en;
  logic [31:0] DATA_to_RxFIFO;
  logic        RxFIFO_wr_en;
  logic        RxFIFO_full = 1'b0;
  logic        SCLK, MOSI, SS_N, busy;
  logic        MISO = 1'b0;

  logic [40:0] data1 = '0;
  logic        empty1 = 1'b1, rd_en1;
  logic [31:0] rx_data1;
  logic        wr_en1;
  logic        full1 = 1'b0;
  logic        sclk1, mosi1, ss_n1, busy1;
  logic        miso1 = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 HCLK = ~HCLK;

  spi_fifo_master #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) u_dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .DATA_from_TxFIFO(DATA_from_TxFIFO), .TxFIFO_empty(TxFIFO_empty), .TxFIFO_rd_en(TxFIFO_rd_en),
    .DATA_to_RxFIFO(DATA_to_RxFIFO), .RxFIFO_wr_en(RxFIFO_wr_en), .RxFIFO_full(RxFIFO_full),
    .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .SS_N(SS_N), .busy(busy)
  );

  spi_fifo_master #(.CLK_DIV(1), .CS_GAP(CS_GAP)) u_dut1 (
    .HCLK(HCLK), .HRESET(HRESET),
    .DATA_from_TxFIFO(data1), .TxFIFO_empty(empty1), .TxFIFO_rd_en(rd_en1),
    .DATA_to_RxFIFO(rx_data1), .RxFIFO_wr_en(wr_en1), .RxFIFO_full(full1),
    .SCLK(sclk1), .MOSI(mosi1), .MISO(miso1), .SS_N(ss_n1), .busy(busy1)
  );

  initial forever begin
    @(posedge HCLK);
    cyc++;
  end

  // TxFIFO model: a pop makes the head visible on the data port before the next edge.
  logic [40:0] tx_q[$];
  int pops = 0;
  initial begin
    DATA_from_TxFIFO = '0;
    TxFIFO_empty = 1'b1;
    forever begin
      @(negedge HCLK);
      if (TxFIFO_rd_en === 1'b1 && tx_q.size() > 0) begin
        DATA_from_TxFIFO = tx_q.pop_front();
        pops++;
      end
      TxFIFO_empty = (tx_q.size() == 0);
    end
  end

  // Mode-0 slave: presents bit 40 when selected, advances on each SCLK fall.
  logic [31:0] slave_words[$];
  logic [40:0] slave_frame = '0;
  int slave_idx = 0;
  initial forever begin
    @(negedge SS_N);
    slave_frame = {9'($urandom), (slave_words.size() > 0) ? slave_words.pop_front() : 32'($urandom)};
    slave_idx = 40;
    MISO = slave_frame[40];
  end
  initial forever begin
    @(negedge SCLK);
    if (SS_N === 1'b0 && slave_idx > 0) begin
      slave_idx--;
      MISO = slave_frame[slave_idx];
    end
  end

  logic [31:0] slave1_word = '0;
  logic [40:0] slave1_frame = '0;
  int slave1_idx = 0;
  initial forever begin
    @(negedge ss_n1);
    slave1_frame = {9'($urandom), slave1_word};
    slave1_idx = 40;
    miso1 = slave1_frame[40];
  end
  initial forever begin
    @(negedge sclk1);
    if (ss_n1 === 1'b0 && slave1_idx > 0) begin
      slave1_idx--;
      miso1 = slave1_frame[slave1_idx];
    end
  end

  // MOSI capture on SCLK rising edges while selected.
  logic [40:0] cap = '0, cap1 = '0;
  int cap_n = 0, cap1_n = 0;
  logic [40:0] mosi_q[$];
  int mosi_n_q[$];
  initial forever begin @(negedge SS_N); cap = '0; cap_n = 0; end
  initial forever begin
    @(posedge SCLK);
    if (SS_N === 1'b0) begin cap = {cap[39:0], MOSI}; cap_n++; end
  end
  initial forever begin @(posedge SS_N); mosi_q.push_back(cap); mosi_n_q.push_back(cap_n); end
  initial forever begin @(negedge ss_n1); cap1 = '0; cap1_n = 0; end
  initial forever begin
    @(posedge sclk1);
    if (ss_n1 === 1'b0) begin cap1 = {cap1[39:0], mosi1}; cap1_n++; end
  end

  // SS_N low/high durations in HCLK cycles, and RxFIFO pushes.
  int low_q[$], gap_q[$];
  logic [31:0] rx_q[$];
  initial begin
    logic ss_prev;
    int edge_cyc;
    ss_prev = 1'b1;
    edge_cyc = 0;
    forever begin
      @(negedge HCLK);
      if (ss_prev === 1'b1 && SS_N === 1'b0) begin
        gap_q.push_back(cyc - edge_cyc);
        edge_cyc = cyc;
      end else if (ss_prev === 1'b0 && SS_N === 1'b1) begin
        low_q.push_back(cyc - edge_cyc);
        edge_cyc = cyc;
      end
      ss_prev = SS_N;
      if (RxFIFO_wr_en === 1'b1) rx_q.push_back(DATA_to_RxFIFO);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1);
  end

  task automatic clear_mon();
    mosi_q.delete();
    mosi_n_q.delete();
    low_q.delete();
    gap_q.delete();
    rx_q.delete();
    slave_words.delete();
    pops = 0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    repeat (4) @(negedge HCLK);
    while ((busy !== 1'b0 || tx_q.size() != 0) && n < 5000) begin
      @(negedge HCLK);
      n++;
    end
    checks++;
    if (n >= 5000) begin
      errors++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, busy, n);
    end
  endtask

  task automatic wait_ss(input logic level, input string name);
    int n;
    n = 0;
    while (SS_N !== level && n < 2000) begin
      @(negedge HCLK);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL %s_ss_wait: SS_N=%b, required %b within 2000 cycles", name, SS_N, level);
    end
  endtask

  task automatic check_frame(input int idx, input logic [40:0] exp, input string name);
    checks++;
    if (mosi_q.size() <= idx) begin
      errors++;
      $display("FAIL %s_frame: only %0d frames seen, required frame %0d", name, mosi_q.size(), idx);
    end else if (mosi_q[idx] !== exp || mosi_n_q[idx] != 41) begin
      errors++;
      $display("FAIL %s_frame: got %h (%0d bits), required %h (41 bits)", name, mosi_q[idx], mosi_n_q[idx], exp);
    end
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    repeat (2) @(negedge HCLK);
    checks++;
    if ({SCLK, SS_N, MOSI, TxFIFO_rd_en, RxFIFO_wr_en, busy} !== 6'b010000) begin
      errors++;
      $display("FAIL reset_pins: SCLK,SS_N,MOSI,rd,wr,busy=%b, required 010000", {SCLK, SS_N, MOSI, TxFIFO_rd_en, RxFIFO_wr_en, busy});
    end
    checks++;
    if (DATA_to_RxFIFO !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got %h, required 00000000", DATA_to_RxFIFO);
    end
    checks++;
    if ({sclk1, ss_n1, mosi1, busy1} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_div1: SCLK,SS_N,MOSI,busy=%b, required 0100", {sclk1, ss_n1, mosi1, busy1});
    end
    HRESET = 1'b0;
    repeat (3) @(negedge HCLK);
    checks++;
    if (TxFIFO_rd_en !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_empty: rd_en=%b busy=%b, required 0 0", TxFIFO_rd_en, busy);
    end
  endtask

  task automatic test_write();
    logic [40:0] pkt;
    for (int i = 0; i < 3; i++) begin
      pkt = (i == 0) ? {1'b1, 8'h3C, 32'hDEADBEEF} : {1'b1, 8'($urandom), 32'($urandom)};
      clear_mon();
      tx_q.push_back(pkt);
      wait_done("write");
      checks++;
      if (pops != 1) begin errors++; $display("FAIL write_pops: got %0d, required 1", pops); end
      check_frame(0, pkt, "write");
      checks++;
      if (low_q.size() != 1 || low_q[0] != FRAME_LOW) begin
        errors++;
        $display("FAIL write_ss_low: got %0d frames, first %0d cycles, required 1 of %0d", low_q.size(), (low_q.size() > 0) ? low_q[0] : -1, FRAME_LOW);
      end
      checks++;
      if (rx_q.size() != 0) begin errors++; $display("FAIL write_no_push: got %0d pushes, required 0", rx_q.size()); end
    end
  endtask

  task automatic test_read();
    logic [40:0] pkt;
    logic [31:0] w;
    for (int i = 0; i < 3; i++) begin
      pkt = (i == 0) ? {1'b0, 8'h81, 32'h0} : {1'b0, 8'($urandom), 32'($urandom)};
      w = (i == 0) ? 32'hA5A51234 : 32'($urandom);
      clear_mon();
      slave_words.push_back(w);
      tx_q.push_back(pkt);
      wait_done("read");
      check_frame(0, pkt, "read");
      checks++;
      if (rx_q.size() != 1 || rx_q[0] !== w) begin
        errors++;
        $display("FAIL read_data: got %0d pushes, first %h, required 1 push of %h", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 32'hx, w);
      end
      checks++;
      if (pops != 1) begin errors++; $display("FAIL read_pops: got %0d, required 1", pops); end
    end
  endtask

  task automatic test_backpressure();
    logic [40:0] pkt, pkt2;
    logic [31:0] w;
    logic ok;
    pkt  = {1'b0, 8'($urandom), 32'($urandom)};
    pkt2 = {1'b1, 8'($urandom), 32'($urandom)};
    w    = 32'($urandom);
    clear_mon();
    RxFIFO_full = 1'b1;
    slave_words.push_back(w);
    tx_q.push_back(pkt);
    tx_q.push_back(pkt2);
    repeat (2) @(negedge HCLK);
    wait_ss(1'b0, "bp");
    wait_ss(1'b1, "bp");
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (busy !== 1'b1 || RxFIFO_wr_en !== 1'b0 || pops != 1 || SS_N !== 1'b1 || SCLK !== 1'b0) ok = 1'b0;
      @(negedge HCLK);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_hold: busy=%b wr_en=%b pops=%0d SS_N=%b SCLK=%b, required 1 0 1 1 0", busy, RxFIFO_wr_en, pops, SS_N, SCLK);
    end
    RxFIFO_full = 1'b0;
    @(negedge HCLK);
    checks++;
    if (RxFIFO_wr_en !== 1'b1 || DATA_to_RxFIFO !== w) begin
      errors++;
      $display("FAIL bp_push: wr_en=%b data=%h, required 1 %h", RxFIFO_wr_en, DATA_to_RxFIFO, w);
    end
    @(negedge HCLK);
    checks++;
    if (RxFIFO_wr_en !== 1'b0) begin errors++; $display("FAIL bp_pulse: wr_en=%b, required 0", RxFIFO_wr_en); end
    wait_done("bp");
    check_frame(1, pkt2, "bp_next");
    checks++;
    if (pops != 2 || rx_q.size() != 1) begin
      errors++;
      $display("FAIL bp_counts: pops=%0d pushes=%0d, required 2 1", pops, rx_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [40:0] pkts[3];
    logic [31:0] exp_rx[$];
    logic [31:0] w;
    int exp_gap;
    clear_mon();
    for (int i = 0; i < 3; i++) begin
      pkts[i] = {(i == 0) ? 1'b0 : (i == 1) ? 1'b1 : 1'($urandom), 8'($urandom), 32'($urandom)};
      w = 32'($urandom);
      slave_words.push_back(w);
      if (pkts[i][40] == 1'b0) exp_rx.push_back(w);
      tx_q.push_back(pkts[i]);
    end
    wait_done("b2b");
    checks++;
    if (pops != 3) begin errors++; $display("FAIL b2b_pops: got %0d, required 3", pops); end
    for (int i = 0; i < 3; i++) check_frame(i, pkts[i], "b2b");
    // Between frames SS_N stays high for the GAP cycles plus IDLE, FETCH and LOAD,
    // and one more cycle when the preceding frame was a read (PUSH).
    for (int i = 1; i < 3; i++) begin
      exp_gap = CS_GAP + 3 + ((pkts[i-1][40] == 1'b0) ? 1 : 0);
      checks++;
      if (gap_q.size() != 3 || gap_q[i] != exp_gap) begin
        errors++;
        $display("FAIL b2b_gap%0d: got %0d (of %0d gaps), required %0d", i, (gap_q.size() > i) ? gap_q[i] : -1, gap_q.size(), exp_gap);
      end
    end
    checks++;
    if (rx_q != exp_rx) begin
      errors++;
      $display("FAIL b2b_rx: got %0d words, required %0d words in order", rx_q.size(), exp_rx.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [40:0] pkt;
    int n;
    clear_mon();
    tx_q.push_back({1'b0, 8'($urandom), 32'($urandom)});
    repeat (2) @(negedge HCLK);
    wait_ss(1'b0, "rst_mid");
    n = 0;
    while (cap_n < 21 && n < 2000) begin @(negedge HCLK); n++; end
    HRESET = 1'b1;
    #1;
    checks++;
    if (SCLK !== 1'b0 || SS_N !== 1'b1 || busy !== 1'b0 || MOSI !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async: SCLK=%b SS_N=%b busy=%b MOSI=%b, required 0 1 0 0", SCLK, SS_N, busy, MOSI);
    end
    repeat (3) @(negedge HCLK);
    HRESET = 1'b0;
    clear_mon();
    pkt = {1'b1, 8'($urandom), 32'($urandom)};
    tx_q.push_back(pkt);
    wait_done("rst_mid");
    check_frame(0, pkt, "rst_mid_next");
    checks++;
    if (rx_q.size() != 0 || pops != 1) begin
      errors++;
      $display("FAIL rst_mid_after: pushes=%0d pops=%0d, required 0 1", rx_q.size(), pops);
    end
  endtask

  task automatic test_clkdiv1();
    logic [40:0] pkt;
    int n, low, pushes;
    logic [31:0] got;
    for (int i = 0; i < 2; i++) begin
      pkt = (i == 0) ? {1'b0, 8'h01, 32'h0} : {1'b0, 8'($urandom), 32'($urandom)};
      slave1_word = (i == 0) ? 32'h0000FFFF : 32'($urandom);
      empty1 = 1'b0;
      n = 0;
      while (rd_en1 !== 1'b1 && n < 20) begin @(negedge HCLK); n++; end
      empty1 = 1'b1;
      data1 = pkt;
      n = 0;
      while (ss_n1 !== 1'b0 && n < 20) begin @(negedge HCLK); n++; end
      low = 0;
      pushes = 0;
      got = '0;
      while (ss_n1 === 1'b0 && low < 1000) begin
        @(negedge HCLK);
        low++;
      end
      for (int k = 0; k < 8; k++) begin
        if (wr_en1 === 1'b1) begin pushes++; got = rx_data1; end
        @(negedge HCLK);
      end
      checks++;
      if (low != 82) begin errors++; $display("FAIL div1_ss_low: got %0d cycles, required 82", low); end
      checks++;
      if (pushes != 1 || got !== slave1_word) begin
        errors++;
        $display("FAIL div1_data: got %0d pushes of %h, required 1 of %h", pushes, got, slave1_word);
      end
      checks++;
      if (cap1 !== pkt || cap1_n != 41) begin
        errors++;
        $display("FAIL div1_frame: got %h (%0d bits), required %h (41 bits)", cap1, cap1_n, pkt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_clkdiv1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
